// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin merge of the I-side and D-side wishbone line masters onto one L2 port.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_CYC,
  input  logic                  i_STB,
  input  logic                  i_WE,
  input  logic [ADDR_WIDTH-1:0] i_ADR,
  input  logic [SEL_WIDTH-1:0]  i_SEL,
  input  logic [DATA_WIDTH-1:0] i_DAT_MOSI,
  output logic [DATA_WIDTH-1:0] i_DAT_MISO,
  output logic                  i_ACK,
  output logic                  i_RTY,
  input  logic                  d_CYC,
  input  logic                  d_STB,
  input  logic                  d_WE,
  input  logic [ADDR_WIDTH-1:0] d_ADR,
  input  logic [SEL_WIDTH-1:0]  d_SEL,
  input  logic [DATA_WIDTH-1:0] d_DAT_MOSI,
  output logic [DATA_WIDTH-1:0] d_DAT_MISO,
  output logic                  d_ACK,
  output logic                  d_RTY,
  output logic                  l2_CYC,
  output logic                  l2_STB,
  output logic                  l2_WE,
  output logic [ADDR_WIDTH-1:0] l2_ADR,
  output logic [SEL_WIDTH-1:0]  l2_SEL,
  output logic [DATA_WIDTH-1:0] l2_DAT_MOSI,
  input  logic [DATA_WIDTH-1:0] l2_DAT_MISO,
  input  logic                  l2_ACK,
  input  logic                  l2_RTY,
  output logic                  grant_d,
  output logic                  conflict_pulse
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t r_state;
  logic   r_last;
  logic   w_i_req, w_d_req, w_busy_i, w_busy_d, w_done;
  assign w_i_req  = i_CYC & i_STB;
  assign w_d_req  = d_CYC & d_STB;
  assign w_busy_i = r_state == BUSY_I;
  assign w_busy_d = r_state == BUSY_D;
  assign w_done   = l2_ACK | l2_RTY;
  // r_last records who finished last; an aborted transaction leaves it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    r_state <= (w_i_req && w_d_req) ? (r_last ? BUSY_I : BUSY_D) :
                            w_d_req ? BUSY_D : w_i_req ? BUSY_I : IDLE;
        BUSY_I:  if (w_done) begin
                   r_state <= IDLE;
                   r_last  <= 1'b0;
                 end else if (!i_CYC) r_state <= IDLE;
        BUSY_D:  if (w_done) begin
                   r_state <= IDLE;
                   r_last  <= 1'b1;
                 end else if (!d_CYC) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign l2_CYC      = w_busy_i ? i_CYC      : w_busy_d ? d_CYC      : 1'b0;
  assign l2_STB      = w_busy_i ? i_STB      : w_busy_d ? d_STB      : 1'b0;
  assign l2_WE       = w_busy_i ? i_WE       : w_busy_d ? d_WE       : 1'b0;
  assign l2_ADR      = w_busy_i ? i_ADR      : w_busy_d ? d_ADR      : '0;
  assign l2_SEL      = w_busy_i ? i_SEL      : w_busy_d ? d_SEL      : '0;
  assign l2_DAT_MOSI = w_busy_i ? i_DAT_MOSI : w_busy_d ? d_DAT_MOSI : '0;
  assign i_DAT_MISO  = l2_DAT_MISO;
  assign d_DAT_MISO  = l2_DAT_MISO;
  assign i_ACK       = w_busy_i & l2_ACK;
  assign i_RTY       = w_busy_i & l2_RTY;
  assign d_ACK       = w_busy_d & l2_ACK;
  assign d_RTY       = w_busy_d & l2_RTY;
  assign grant_d        = w_busy_d;
  assign conflict_pulse = (r_state == IDLE) & w_i_req & w_d_req;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios for the I/D to L2 wishbone arbiter.
module tb_l2_arbiter;
  logic         clk = 1'b0, reset = 1'b0;
  logic         i_CYC, i_STB, i_WE, d_CYC, d_STB, d_WE;
  logic [11:0]  i_ADR, d_ADR, l2_ADR;
  logic [15:0]  i_SEL, d_SEL, l2_SEL;
  logic [127:0] i_DAT_MOSI, d_DAT_MOSI, i_DAT_MISO, d_DAT_MISO, l2_DAT_MOSI, l2_DAT_MISO;
  logic         i_ACK, i_RTY, d_ACK, d_RTY, l2_CYC, l2_STB, l2_WE, l2_ACK, l2_RTY;
  logic         grant_d, conflict_pulse;
  int           tests = 0, fails = 0;
  logic [127:0] pat_a5, pat_wr;

  l2_arbiter dut (
    .clk(clk), .reset(reset),
    .i_CYC(i_CYC), .i_STB(i_STB), .i_WE(i_WE), .i_ADR(i_ADR), .i_SEL(i_SEL),
    .i_DAT_MOSI(i_DAT_MOSI), .i_DAT_MISO(i_DAT_MISO), .i_ACK(i_ACK), .i_RTY(i_RTY),
    .d_CYC(d_CYC), .d_STB(d_STB), .d_WE(d_WE), .d_ADR(d_ADR), .d_SEL(d_SEL),
    .d_DAT_MOSI(d_DAT_MOSI), .d_DAT_MISO(d_DAT_MISO), .d_ACK(d_ACK), .d_RTY(d_RTY),
    .l2_CYC(l2_CYC), .l2_STB(l2_STB), .l2_WE(l2_WE), .l2_ADR(l2_ADR), .l2_SEL(l2_SEL),
    .l2_DAT_MOSI(l2_DAT_MOSI), .l2_DAT_MISO(l2_DAT_MISO), .l2_ACK(l2_ACK), .l2_RTY(l2_RTY),
    .grant_d(grant_d), .conflict_pulse(conflict_pulse)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {i_CYC, i_STB, i_WE, d_CYC, d_STB, d_WE, l2_ACK, l2_RTY} = '0;
    i_ADR = '0; d_ADR = '0; i_SEL = '0; d_SEL = '0;
    i_DAT_MOSI = '0; d_DAT_MOSI = '0; l2_DAT_MISO = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    tests++;
    if ({l2_CYC, l2_STB, l2_WE, i_ACK, i_RTY, d_ACK, d_RTY, grant_d, conflict_pulse} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {l2_CYC, l2_STB, l2_WE, i_ACK, i_RTY, d_ACK, d_RTY, grant_d, conflict_pulse});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_i_read();
    do_reset();
    i_CYC = 1; i_STB = 1; i_WE = 0; i_ADR = 12'h123;
    #1;
    tests++;
    if (l2_CYC !== 1'b0) begin fails++; $display("FAIL iread_c0_l2cyc: got %b expected 0", l2_CYC); end
    cyc();
    tests++;
    if ({l2_CYC, l2_STB, l2_ADR} !== {2'b11, 12'h123}) begin
      fails++; $display("FAIL iread_c1_fwd: got %b%b %h expected 11 123", l2_CYC, l2_STB, l2_ADR);
    end
    cyc();
    cyc();
    cyc();
    l2_ACK = 1; l2_DAT_MISO = pat_a5;
    #1;
    tests++;
    if ({i_ACK, d_ACK, i_DAT_MISO} !== {2'b10, pat_a5}) begin
      fails++; $display("FAIL iread_c4_ack: got %b%b %h expected 10 %h", i_ACK, d_ACK, i_DAT_MISO, pat_a5);
    end
    cyc();
    l2_ACK = 0; i_CYC = 0; i_STB = 0;
    #1;
    tests++;
    if (l2_CYC !== 1'b0) begin fails++; $display("FAIL iread_c5_l2cyc: got %b expected 0", l2_CYC); end
  endtask

  task automatic test_conflict();
    do_reset();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h111;
    d_CYC = 1; d_STB = 1; d_ADR = 12'h222;
    #1;
    tests++;
    if ({conflict_pulse, l2_CYC} !== 2'b10) begin
      fails++; $display("FAIL conflict_pulse: got %b%b expected 10", conflict_pulse, l2_CYC);
    end
    cyc();
    tests++;
    if ({grant_d, l2_CYC, l2_ADR, conflict_pulse} !== {2'b11, 12'h222, 1'b0}) begin
      fails++; $display("FAIL conflict_d_first: got %b%b %h %b expected 11 222 0", grant_d, l2_CYC, l2_ADR, conflict_pulse);
    end
    l2_ACK = 1;
    #1;
    tests++;
    if ({d_ACK, i_ACK} !== 2'b10) begin fails++; $display("FAIL conflict_d_ack: got %b%b expected 10", d_ACK, i_ACK); end
    cyc();
    l2_ACK = 0; d_CYC = 0; d_STB = 0;
    #1;
    tests++;
    if ({l2_CYC, i_ACK, grant_d} !== 3'b000) begin
      fails++; $display("FAIL conflict_gap: got %b%b%b expected 000", l2_CYC, i_ACK, grant_d);
    end
    cyc();
    tests++;
    if ({l2_CYC, grant_d, l2_ADR} !== {2'b10, 12'h111}) begin
      fails++; $display("FAIL conflict_i_next: got %b%b %h expected 10 111", l2_CYC, grant_d, l2_ADR);
    end
    l2_ACK = 1;
    #1;
    tests++;
    if ({i_ACK, d_ACK} !== 2'b10) begin fails++; $display("FAIL conflict_i_ack: got %b%b expected 10", i_ACK, d_ACK); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_fairness();
    do_reset();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0AA;
    d_CYC = 1; d_STB = 1; d_ADR = 12'h0DD;
    for (int k = 0; k < 6; k++) begin
      cyc();
      tests++;
      if ({l2_CYC, grant_d, l2_ADR} !== {1'b1, k % 2 == 0, (k % 2 == 0) ? 12'h0DD : 12'h0AA}) begin
        fails++; $display("FAIL fair_grant_%0d: got %b%b %h", k, l2_CYC, grant_d, l2_ADR);
      end
      l2_ACK = 1;
      #1;
      tests++;
      if ({i_ACK, d_ACK} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL fair_ack_%0d: got i=%b d=%b", k, i_ACK, d_ACK);
      end
      cyc();
      l2_ACK = 0;
      #1;
      tests++;
      if ({l2_CYC, conflict_pulse} !== 2'b01) begin
        fails++; $display("FAIL fair_idle_%0d: got %b%b expected 01", k, l2_CYC, conflict_pulse);
      end
    end
    idle_inputs();
  endtask

  task automatic test_d_write_rty();
    do_reset();
    d_CYC = 1; d_STB = 1; d_WE = 1; d_ADR = 12'h3C5; d_SEL = 16'hFFFF; d_DAT_MOSI = pat_wr;
    cyc();
    tests++;
    if ({l2_CYC, l2_STB, l2_WE, grant_d, l2_ADR, l2_SEL, l2_DAT_MOSI} !== {4'b1111, 12'h3C5, 16'hFFFF, pat_wr}) begin
      fails++; $display("FAIL dwrite_fwd: got %b%b%b%b %h %h %h", l2_CYC, l2_STB, l2_WE, grant_d, l2_ADR, l2_SEL, l2_DAT_MOSI);
    end
    l2_RTY = 1;
    #1;
    tests++;
    if ({d_RTY, i_RTY, d_ACK, i_ACK} !== 4'b1000) begin
      fails++; $display("FAIL dwrite_rty: got %b%b%b%b expected 1000", d_RTY, i_RTY, d_ACK, i_ACK);
    end
    cyc();
    l2_RTY = 0; d_CYC = 0; d_STB = 0; d_WE = 0;
    #1;
    tests++;
    if ({grant_d, l2_CYC} !== 2'b00) begin fails++; $display("FAIL dwrite_idle: got %b%b expected 00", grant_d, l2_CYC); end
  endtask

  task automatic test_abort();
    do_reset();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h044;
    cyc();
    tests++;
    if (l2_CYC !== 1'b1) begin fails++; $display("FAIL abort_granted: got %b expected 1", l2_CYC); end
    cyc();
    cyc();
    i_CYC = 0;
    #1;
    tests++;
    if (l2_CYC !== 1'b0) begin fails++; $display("FAIL abort_c3_l2cyc: got %b expected 0", l2_CYC); end
    cyc();
    i_CYC = 1; d_CYC = 1; d_STB = 1; d_ADR = 12'h055;
    #1;
    tests++;
    if ({l2_CYC, conflict_pulse} !== 2'b01) begin
      fails++; $display("FAIL abort_c4_idle: got %b%b expected 01", l2_CYC, conflict_pulse);
    end
    cyc();
    tests++;
    if ({grant_d, l2_ADR} !== {1'b1, 12'h055}) begin
      fails++; $display("FAIL abort_d_grant: got %b %h expected 1 055", grant_d, l2_ADR);
    end
    d_CYC = 0;
    cyc();
    d_CYC = 1;
    #1;
    tests++;
    if ({l2_CYC, conflict_pulse} !== 2'b01) begin
      fails++; $display("FAIL abort_d_idle: got %b%b expected 01", l2_CYC, conflict_pulse);
    end
    cyc();
    tests++;
    if (grant_d !== 1'b1) begin fails++; $display("FAIL abort_last_kept: got %b expected 1", grant_d); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_busy();
    do_reset();
    d_CYC = 1; d_STB = 1; d_ADR = 12'h0F0;
    cyc();
    tests++;
    if (grant_d !== 1'b1) begin fails++; $display("FAIL rstbusy_grant: got %b expected 1", grant_d); end
    reset = 1;
    cyc();
    reset = 0; l2_ACK = 1; l2_DAT_MISO = pat_a5;
    #1;
    tests++;
    if ({l2_CYC, grant_d, d_ACK, i_ACK} !== 4'b0000) begin
      fails++; $display("FAIL rstbusy_after: got %b%b%b%b expected 0000", l2_CYC, grant_d, d_ACK, i_ACK);
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_wr = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    idle_inputs();
    test_reset();
    test_single_i_read();
    test_conflict();
    test_fairness();
    test_d_write_rty();
    test_abort();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
